// File: rtl/filt_out_capture.sv
// Capture stage behind the Butterworth filter: it drops the start-up transient,
// decimates the sample stream and queues the kept samples for a valid/ready reader.
module filt_out_capture #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int DECIM_W = 8,
    parameter int SETTLE  = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     en,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The cycle in which en is first seen high is the first discarded sample.
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 1) ? SETTLE - 1 : 0);
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [DECIM_W-1:0] dec_q, dec_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic keep_s, empty_s, full_s, pop_s, push_s, drop_s;

    // Capture sequencing: idle, transient discard, decimated run.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        dec_d    = dec_q;
        if (!en) begin
            state_d  = ST_IDLE;
            settle_d = {SW{1'b0}};
            dec_d    = {DECIM_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dec_d = {DECIM_W{1'b0}};
                    if (SETTLE > 1) begin
                        state_d  = ST_SETTLE;
                        settle_d = SW'(1);
                    end else begin
                        state_d  = ST_RUN;
                        settle_d = {SW{1'b0}};
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_RUN;
                        settle_d = {SW{1'b0}};
                        dec_d    = {DECIM_W{1'b0}};
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // >= also catches a decim lowered below the current count.
                    if (dec_q >= decim) begin
                        dec_d = {DECIM_W{1'b0}};
                    end else begin
                        dec_d = dec_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    settle_d = {SW{1'b0}};
                    dec_d    = {DECIM_W{1'b0}};
                end
            endcase
        end
    end

    // FIFO bookkeeping: push/pop/drop decisions and sticky overflow.
    always_comb begin
        keep_s  = en && (state_q == ST_RUN) && (dec_q == {DECIM_W{1'b0}});
        empty_s = (count_q == {(AW + 1){1'b0}});
        full_s  = (count_q == FULL_CNT);
        pop_s   = !empty_s && rd_ready;
        push_s  = keep_s && (!full_s || pop_s);
        drop_s  = keep_s && full_s && !pop_s;
        wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            settle_q   <= {SW{1'b0}};
            dec_q      <= {DECIM_W{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW + 1){1'b0}};
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            dec_q      <= dec_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= (count_d != {(AW + 1){1'b0}});
        end
    end

    // Sample storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= sample_in;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_filt_out_capture.sv
// Directed and randomized bench for filt_out_capture against a queue-based
// model: a sample is kept when en has been high k cycles with k>=SETTLE and (k-SETTLE)%(decim+1)==0.
module tb_filt_out_capture;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int DECIM_W = 8;
    localparam int SETTLE  = 8;

    logic                    CLK;
    logic                    RST_N;
    logic                    en;
    logic [DECIM_W-1:0]      decim;
    logic [DATA_W-1:0]       sample_in;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [DATA_W-1:0]       rd_data;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    clr_ovf;

    int errs   = 0;
    int checks = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] popped[$];
    logic              ovf_m;
    int                en_cyc;

    filt_out_capture #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W), .SETTLE(SETTLE)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .en(en), .decim(decim), .sample_in(sample_in),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        en_cyc = 0;
    endtask

    // Called at a falling edge with inputs already applied: check, advance model, step one clock.
    task automatic tick();
        bit pop_m, keep_m, full_m, drop_m;
        int k;
        chk("rd_valid", {31'd0, rd_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk("count", {27'd0, count}, q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        if (q.size() != 0) chk("rd_data", {16'd0, rd_data}, {16'd0, q[0]});
        pop_m  = rd_ready && (q.size() != 0);
        if (pop_m) popped.push_back(rd_data);
        keep_m = 1'b0;
        if (en) begin
            k      = en_cyc;
            en_cyc = en_cyc + 1;
            keep_m = (k >= SETTLE) && (((k - SETTLE) % (int'(decim) + 1)) == 0);
        end else begin
            en_cyc = 0;
        end
        full_m = (q.size() == DEPTH);
        drop_m = 1'b0;
        if (pop_m) void'(q.pop_front());
        if (keep_m) begin
            if (full_m && !pop_m) drop_m = 1'b1;
            else q.push_back(sample_in);
        end
        if (drop_m) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_dec [3];
        exp_dec = '{16'h1000, 16'h1800, 16'h2000};
        RST_N = 1'b0; en = 1'b0; decim = 8'd0; sample_in = 16'd0;
        rd_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #3;
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", {16'd0, rd_data}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Idle: nothing captured while en is low.
        for (int i = 0; i < 5; i++) begin
            sample_in = 16'($urandom); rd_ready = 1'(i % 2);
            tick();
        end

        // Settle then capture every sample of a 0x200 ramp; overfill the FIFO.
        decim = 8'd0; rd_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample_in = DATA_W'(i * 32'h200);
            tick();
        end
        chk("first_head", {16'd0, rd_data}, 32'h1000);
        chk("first_count", {27'd0, count}, 32'd4);
        for (int i = 12; i < 36; i++) begin
            sample_in = DATA_W'(i * 32'h200);
            tick();
        end
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_ovf", {31'd0, overflow}, 32'd1);
        chk("full_head", {16'd0, rd_data}, 32'h1000);

        // Full: clear collides with a fresh drop, then a pop lets the push in.
        sample_in = 16'hAAAA; clr_ovf = 1'b1; rd_ready = 1'b0;
        tick();
        chk("set_wins", {31'd0, overflow}, 32'd1);
        sample_in = 16'h5555; clr_ovf = 1'b1; rd_ready = 1'b1;
        tick();
        chk("pop_full_count", {27'd0, count}, 32'd16);
        chk("pop_full_ovf", {31'd0, overflow}, 32'd0);
        chk("pop_full_head", {16'd0, rd_data}, 32'h1200);

        // Drain with en low; extra ready cycles on an empty FIFO do nothing.
        clr_ovf = 1'b0; en = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_in = 16'($urandom);
            tick();
        end

        // Decimation by 4 with the reader always ready.
        popped.delete();
        decim = 8'd3; en = 1'b1; rd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample_in = DATA_W'(i * 32'h200);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("dec_seq", (i < popped.size()) ? {16'd0, popped[i]} : 32'hDEADBEEF,
                {16'd0, exp_dec[i]});
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Random backpressure and data with a two-cycle en drop mid-run.
        decim = 8'd1;
        for (int i = 0; i < 300; i++) begin
            en        = !(i >= 150 && i < 152);
            rd_ready  = 1'($urandom_range(0, 1));
            sample_in = 16'($urandom);
            clr_ovf   = (i % 97 == 50);
            tick();
        end
        en = 1'b0; rd_ready = 1'b1; clr_ovf = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("drained", {27'd0, count}, 32'd0);
        clr_ovf = 1'b0;

        // Fill five entries, then reset asynchronously between clock edges.
        decim = 8'd0; rd_ready = 1'b0; en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            sample_in = 16'($urandom);
            tick();
        end
        chk("pre_rst_count", {27'd0, count}, 32'd5);
        #1 RST_N = 1'b0;
        #2;
        chk("mid_rst_count", {27'd0, count}, 32'd0);
        chk("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        #1 RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            sample_in = DATA_W'(i * 32'h200);
            tick();
        end
        chk("post_rst_head", {16'd0, rd_data}, 32'h1000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
